// File: rtl/bomb_pkg.sv
// Shared types and constants for the bomb controller: slot states, grid size, timing defaults.
package bomb_pkg;

  typedef enum logic [1:0] {
    SLOT_IDLE  = 2'd0,
    SLOT_ARMED = 2'd1,
    SLOT_BLAST = 2'd2
  } slot_state_e;

  localparam int GRID_W          = 16;
  localparam int GRID_H          = 16;
  localparam int FUSE_TICKS_DEF  = 120;
  localparam int BLAST_TICKS_DEF = 30;
  localparam int RANGE_DEF       = 2;
  localparam int CNT_W           = 7;

  function automatic logic [GRID_W*GRID_H-1:0] onehot_tile(input logic [7:0] cor);
    logic [GRID_W*GRID_H-1:0] v;
    v      = '0;
    v[cor] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/bomb_blast_mask.sv
// Combinational blast footprint: centre tile plus RANGE tiles per arm, clipped at grid edges and walls.
module bomb_blast_mask
  import bomb_pkg::*;
#(
  parameter int RANGE = RANGE_DEF
) (
  input  logic [7:0]               cor_i,
  input  logic [GRID_W*GRID_H-1:0] wall_i,
  output logic [GRID_W*GRID_H-1:0] mask_o
);

  int         row, col, rr, cc, lin;
  logic       arm_open;
  logic [7:0] tidx;

  always_comb begin
    mask_o   = onehot_tile(cor_i);
    row      = int'(cor_i[7:4]);
    col      = int'(cor_i[3:0]);
    rr       = 0;
    cc       = 0;
    lin      = 0;
    tidx     = '0;
    arm_open = 1'b0;
    for (int d = 0; d < 4; d++) begin
      arm_open = 1'b1;
      for (int k = 1; k <= RANGE; k++) begin
        rr = row;
        cc = col;
        case (d)
          0:       rr = row - k;
          1:       rr = row + k;
          2:       cc = col - k;
          default: cc = col + k;
        endcase
        lin  = rr * GRID_W + cc;
        tidx = lin[7:0];
        // Once an arm leaves the grid or hits a wall, nothing further along it is lit.
        if (rr < 0 || rr >= GRID_H || cc < 0 || cc >= GRID_W) arm_open = 1'b0;
        else if (wall_i[tidx]) arm_open = 1'b0;
        if (arm_open) mask_o[tidx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bomb_ctrl.sv
// Bomb slot manager for two players: placement arbitration, fuse/blast timers, chain reactions.
// Blast and bomb maps are combinational from the slot registers.
module bomb_ctrl
  import bomb_pkg::*;
#(
  parameter int FUSE_TICKS       = FUSE_TICKS_DEF,
  parameter int BLAST_TICKS      = BLAST_TICKS_DEF,
  parameter int RANGE            = RANGE_DEF,
  parameter int SLOTS_PER_PLAYER = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_tick,
  input  logic                     i_place_p1,
  input  logic                     i_place_p2,
  input  logic [7:0]               p1_cor,
  input  logic [7:0]               p2_cor,
  input  logic [GRID_W*GRID_H-1:0] i_wall,
  input  logic                     i_freeze,
  output logic [GRID_W*GRID_H-1:0] o_explode,
  output logic [GRID_W*GRID_H-1:0] o_bomb,
  output logic [1:0]               o_p1_left,
  output logic [1:0]               o_p2_left
);

  localparam int NS = 2 * SLOTS_PER_PLAYER;
  localparam int MW = GRID_W * GRID_H;
  localparam logic [CNT_W-1:0] FUSE_INIT  = CNT_W'(FUSE_TICKS);
  localparam logic [CNT_W-1:0] BLAST_INIT = CNT_W'(BLAST_TICKS);

  slot_state_e      state_q [NS];
  logic [7:0]       cor_q   [NS];
  logic [CNT_W-1:0] cnt_q   [NS];
  logic [MW-1:0]    mask    [NS];

  logic p1_free, p2_free, p1_ok, p2_ok;
  int   p1_idx, p2_idx;

  for (genvar g = 0; g < NS; g++) begin : g_slot
    bomb_blast_mask #(.RANGE(RANGE)) u_mask (
      .cor_i  (cor_q[g]),
      .wall_i (i_wall),
      .mask_o (mask[g])
    );
  end

  // Slots [0, SLOTS_PER_PLAYER) belong to P1, the rest to P2; scan downward so the lowest idle wins.
  always_comb begin
    o_explode = '0;
    o_bomb    = '0;
    o_p1_left = '0;
    o_p2_left = '0;
    p1_free   = 1'b0;
    p2_free   = 1'b0;
    p1_idx    = 0;
    p2_idx    = 0;
    for (int i = 0; i < NS; i++) begin
      if (state_q[i] == SLOT_BLAST) o_explode = o_explode | mask[i];
      if (state_q[i] == SLOT_ARMED) o_bomb = o_bomb | onehot_tile(cor_q[i]);
    end
    for (int i = SLOTS_PER_PLAYER - 1; i >= 0; i--) begin
      if (state_q[i] == SLOT_IDLE) begin
        p1_free   = 1'b1;
        p1_idx    = i;
        o_p1_left = o_p1_left + 2'd1;
      end
    end
    for (int i = NS - 1; i >= SLOTS_PER_PLAYER; i--) begin
      if (state_q[i] == SLOT_IDLE) begin
        p2_free   = 1'b1;
        p2_idx    = i;
        o_p2_left = o_p2_left + 2'd1;
      end
    end
  end

  assign p1_ok = i_place_p1 && !i_freeze && p1_free &&
                 !o_bomb[p1_cor] && !o_explode[p1_cor] && !i_wall[p1_cor];
  assign p2_ok = i_place_p2 && !i_freeze && p2_free &&
                 !o_bomb[p2_cor] && !o_explode[p2_cor] && !i_wall[p2_cor] &&
                 !(p1_ok && (p1_cor == p2_cor));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NS; i++) begin
        state_q[i] <= SLOT_IDLE;
        cor_q[i]   <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NS; i++) begin
        case (state_q[i])
          SLOT_IDLE: begin
            if (p1_ok && i == p1_idx) begin
              state_q[i] <= SLOT_ARMED;
              cor_q[i]   <= p1_cor;
              cnt_q[i]   <= FUSE_INIT;
            end else if (p2_ok && i == p2_idx) begin
              state_q[i] <= SLOT_ARMED;
              cor_q[i]   <= p2_cor;
              cnt_q[i]   <= FUSE_INIT;
            end
          end
          SLOT_ARMED: begin
            // A neighbouring blast detonates this bomb immediately, ignoring the fuse.
            if (o_explode[cor_q[i]] || (i_tick && cnt_q[i] == CNT_W'(1))) begin
              state_q[i] <= SLOT_BLAST;
              cnt_q[i]   <= BLAST_INIT;
            end else if (i_tick) begin
              cnt_q[i] <= cnt_q[i] - CNT_W'(1);
            end
          end
          SLOT_BLAST: begin
            if (i_tick) begin
              if (cnt_q[i] == CNT_W'(1)) begin
                state_q[i] <= SLOT_IDLE;
                cnt_q[i]   <= '0;
              end else begin
                cnt_q[i] <= cnt_q[i] - CNT_W'(1);
              end
            end
          end
          default: state_q[i] <= SLOT_IDLE;
        endcase
      end
    end
  end

endmodule
